ball_engine: RTL and testbench
==============================

# ball_engine

Ball physics and rally/score sequencer for the Pong game. Once per frame tick it advances the ball, bounces it off the top and bottom walls and both paddles, and detects points. It runs the serve delay and the game-over hold. It consumes both paddle y positions from the player input stages and produces the ball position that the game server distributes to both display wrappers.

## Interface
Parameters:
- SCREEN_W, 800: playfield width in pixels.
- SCREEN_H, 600: playfield height in pixels.
- BALL_SIZE, 8: ball edge length in pixels; the ball is square.
- PADDLE_H, 80: paddle height in pixels.
- PADDLE_W, 10: paddle width in pixels.
- P1_X, 20: x of the left edge of paddle 1.
- P2_X, 770: x of the left edge of paddle 2; this is paddle 2's hitting face.
- SPEED, 4: pixels moved per tick on each axis.
- TICK_DIV, 416667: clock cycles per game tick (120 Hz at 50 MHz).
- SERVE_TICKS, 120: ticks the ball is held at centre before each serve.
- WIN_SCORE, 7: score that ends the game.

Ports:
- clock, in, 1: system clock (CLOCK_50 domain).
- reset_n, in, 1: asynchronous reset, active-low.
- start, in, 1: when high in GAME_OVER, starts a new game.
- pause, in, 1: while high, ticks are ignored and all state is held.
- p1_y, in, 11: top y of paddle 1.
- p2_y, in, 11: top y of paddle 2.
- ball_x, out, 11: top-left x of the ball.
- ball_y, out, 11: top-left y of the ball.
- score1, out, 4: score of player 1.
- score2, out, 4: score of player 2.
- point_p1, out, 1: one-cycle pulse when player 1 scores.
- point_p2, out, 1: one-cycle pulse when player 2 scores.
- serving, out, 1: high while the FSM is in SERVE.
- game_over, out, 1: high while the FSM is in GAME_OVER.

## Operation
- Tick generator: a free-running counter counts 0..TICK_DIV-1 and wraps. `tick` is asserted on the count TICK_DIV-1. A tick is effective only when it occurs and pause=0.
- Centre position: CX = (SCREEN_W-BALL_SIZE)/2 and CY = (SCREEN_H-BALL_SIZE)/2, i.e. 396 and 296 at the defaults.
- Direction bits: dx (1 = right) and dy (1 = down).
- FSM states: SERVE, PLAY, GAME_OVER.

SERVE:
- The ball is held at (CX,CY).
- Each effective tick increments serve_cnt.
- When serve_cnt reaches SERVE_TICKS-1 on an effective tick, serve_cnt clears and the FSM enters PLAY. The ball does not move on that tick.

PLAY (work is done only on effective ticks):
- All comparisons use 12-bit unsigned arithmetic; there is no underflow.
- Vertical motion:
  - dy=1 and y+SPEED >= SCREEN_H-BALL_SIZE: y = SCREEN_H-BALL_SIZE, dy = 0.
  - dy=0 and y <= SPEED: y = 0, dy = 1.
  - Otherwise y moves by SPEED.
- Overlap with a paddle means ball_y+BALL_SIZE > py and ball_y < py+PADDLE_H. It uses ball_y before this tick's update.
- Moving left (dx=0):
  - If x >= P1_X+PADDLE_W, x-SPEED < P1_X+PADDLE_W, and the ball overlaps p1_y: x = P1_X+PADDLE_W, dx = 1.
  - Else if x < SPEED: player 2 scores.
  - Otherwise x = x-SPEED.
- Moving right (dx=1):
  - If x+BALL_SIZE <= P2_X, x+BALL_SIZE+SPEED > P2_X, and the ball overlaps p2_y: x = P2_X-BALL_SIZE, dx = 0.
  - Else if x+BALL_SIZE+SPEED > SCREEN_W: player 1 scores.
  - Otherwise x = x+SPEED.
- The horizontal and vertical updates are independent and both apply in the same tick, which covers corner hits.
- On a score:
  - The scorer's counter increments and the matching point pulse fires.
  - The ball returns to centre.
  - dx is set toward the player who conceded: dx=0 when player 1 conceded, dx=1 when player 2 conceded. dy is kept.
  - If the new score equals WIN_SCORE, the FSM enters GAME_OVER; otherwise it enters SERVE.
  - A score takes precedence over the vertical update for that tick.

GAME_OVER:
- The ball is held at centre and the scores are frozen.
- start=1 clears both scores and serve_cnt and enters SERVE. This does not wait for a tick.

Pause:
- The tick counter keeps running.
- FSM, position, direction and scores are held. A start in GAME_OVER is still honoured.

## Timing
- Reset values (asynchronous):
  - tick counter 0, state SERVE, serve_cnt 0.
  - ball_x = CX, ball_y = CY, dx = 1, dy = 1.
  - score1 = score2 = 0, point_p1 = point_p2 = 0.
  - serving = 1, game_over = 0.
- All outputs are registered.
- ball_x and ball_y change one cycle after the tick cycle.
- point_p1/point_p2 assert for exactly one cycle, in the same cycle the score register updates.
- p1_y and p2_y are sampled only on the effective-tick cycle.
- Reset asserted mid-rally returns every register to its reset value immediately.
- First motion after reset occurs SERVE_TICKS+1 effective ticks after reset release.

## Test plan
All scenarios use TICK_DIV=4 and SERVE_TICKS=2; other parameters are at their defaults.

- Reset/serve: after reset, expect (396,296), serving=1, scores 0. After 2 ticks, expect PLAY. On the 3rd tick, expect (400,300).
- Bottom wall: force a rally with ball_y near 590 and dy=1. Expect ball_y clamped to 592, then 588 on the next tick.
- Paddle 1 return: set p1_y=260 and let the ball travel left. Expect ball_x clamped to 30, dx flips, and the next x is 34.
- Miss: set p1_y=0 with the ball moving left at y=296. Expect point_p2 pulse for 1 cycle, score2=1, ball at (396,296), serving=1, dx=0.
- Game over: player 1 scores seven times. Expect game_over=1 and score1=7, and the ball frozen across 10 ticks. Pulse start: expect scores 0, serving=1.
- Pause/reset: hold pause for 20 ticks mid-rally and expect position unchanged. Assert reset_n low mid-rally and expect all reset values asynchronously.

Source files
------------

// File: rtl/ball_engine.sv
// Ball physics and rally/score sequencer for Pong: advances the ball once per game tick,
// bounces it off walls and paddles, scores points and runs the serve and game-over holds.
module ball_engine #(
  parameter int unsigned SCREEN_W    = 800,
  parameter int unsigned SCREEN_H    = 600,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_H    = 80,
  parameter int unsigned PADDLE_W    = 10,
  parameter int unsigned P1_X        = 20,
  parameter int unsigned P2_X        = 770,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned TICK_DIV    = 416667,
  parameter int unsigned SERVE_TICKS = 120,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pause,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        point_p1,
  output logic        point_p2,
  output logic        serving,
  output logic        game_over
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ServeW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [11:0] Cx     = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] Cy     = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] Spd    = 12'(SPEED);
  localparam logic [11:0] Bsz    = 12'(BALL_SIZE);
  localparam logic [11:0] Ph     = 12'(PADDLE_H);
  localparam logic [11:0] P1Face = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] P2Face = 12'(P2_X);
  localparam logic [11:0] P2Stop = 12'(P2_X - BALL_SIZE);
  localparam logic [11:0] YMax   = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] XLim   = 12'(SCREEN_W);
  localparam logic [3:0]  Win    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StServe, StPlay, StGameOver} state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ServeW-1:0] serve_cnt_q, serve_cnt_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  logic [3:0]        score1_q, score1_d, score2_q, score2_d;
  logic              pt1_q, pt1_d, pt2_q, pt2_d;

  logic        tick, eff_tick, serve_done, play_tick;
  logic        p1_scores, p2_scores, miss_left, miss_right, win1, win2;
  logic [11:0] x12, y12, py1, py2;
  logic        ov1, ov2;
  logic [10:0] x_mv, y_mv;
  logic        dx_mv, dy_mv;

  assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  assign eff_tick   = tick & ~pause;
  assign serve_done = (state_q == StServe) && eff_tick &&
                      (serve_cnt_q == ServeW'(SERVE_TICKS - 1));
  assign play_tick  = (state_q == StPlay) && eff_tick;

  assign x12 = {1'b0, x_q};
  assign y12 = {1'b0, y_q};
  assign py1 = {1'b0, p1_y};
  assign py2 = {1'b0, p2_y};
  // Overlap is judged on the ball's row before this tick's vertical step.
  assign ov1 = (y12 + Bsz > py1) && (y12 < py1 + Ph);
  assign ov2 = (y12 + Bsz > py2) && (y12 < py2 + Ph);

  always_comb begin
    y_mv  = y_q;
    dy_mv = dy_q;
    if (dy_q && (y12 + Spd >= YMax)) begin
      y_mv  = YMax[10:0];
      dy_mv = 1'b0;
    end else if (!dy_q && (y12 <= Spd)) begin
      y_mv  = '0;
      dy_mv = 1'b1;
    end else if (dy_q) begin
      y_mv = y_q + Spd[10:0];
    end else begin
      y_mv = y_q - Spd[10:0];
    end
  end

  always_comb begin
    x_mv       = x_q;
    dx_mv      = dx_q;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    if (!dx_q) begin
      if ((x12 >= P1Face) && (x12 - Spd < P1Face) && ov1) begin
        x_mv  = P1Face[10:0];
        dx_mv = 1'b1;
      end else if (x12 < Spd) begin
        miss_left = 1'b1;
      end else begin
        x_mv = x_q - Spd[10:0];
      end
    end else begin
      if ((x12 + Bsz <= P2Face) && (x12 + Bsz + Spd > P2Face) && ov2) begin
        x_mv  = P2Stop[10:0];
        dx_mv = 1'b0;
      end else if (x12 + Bsz + Spd > XLim) begin
        miss_right = 1'b1;
      end else begin
        x_mv = x_q + Spd[10:0];
      end
    end
  end

  assign p1_scores = play_tick & miss_right;
  assign p2_scores = play_tick & miss_left;
  assign win1      = (score1_q + 4'd1) == Win;
  assign win2      = (score2_q + 4'd1) == Win;

  // Datapath next-state: position, direction, scores, serve counter, point pulses.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_cnt_d = serve_cnt_q;
    pt1_d       = 1'b0;
    pt2_d       = 1'b0;
    unique case (state_q)
      StServe: begin
        if (eff_tick) serve_cnt_d = serve_done ? '0 : serve_cnt_q + ServeW'(1);
      end
      StPlay: begin
        if (p1_scores || p2_scores) begin
          x_d  = Cx[10:0];
          y_d  = Cy[10:0];
          dx_d = p1_scores;
          if (p1_scores) begin
            score1_d = score1_q + 4'd1;
            pt1_d    = 1'b1;
          end else begin
            score2_d = score2_q + 4'd1;
            pt2_d    = 1'b1;
          end
        end else if (play_tick) begin
          x_d  = x_mv;
          y_d  = y_mv;
          dx_d = dx_mv;
          dy_d = dy_mv;
        end
      end
      StGameOver: begin
        if (start) begin
          score1_d    = '0;
          score2_d    = '0;
          serve_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StServe:    if (serve_done) state_d = StPlay;
      StPlay: begin
        if (p1_scores)      state_d = win1 ? StGameOver : StServe;
        else if (p2_scores) state_d = win2 ? StGameOver : StServe;
      end
      StGameOver: if (start) state_d = StServe;
      default:    state_d = StServe;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StServe;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      x_q         <= Cx[10:0];
      y_q         <= Cy[10:0];
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      pt1_q       <= 1'b0;
      pt2_q       <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      pt1_q       <= pt1_d;
      pt2_q       <= pt2_d;
    end
  end

  always_comb begin
    serving   = (state_q == StServe);
    game_over = (state_q == StGameOver);
  end

  assign ball_x   = x_q;
  assign ball_y   = y_q;
  assign score1   = score1_q;
  assign score2   = score2_q;
  assign point_p1 = pt1_q;
  assign point_p2 = pt2_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: drives paddles/pause/start and compares every cycle
// against a tick-level reference model of the rally rules.
module tb_ball_engine;

  localparam int TickDiv    = 4;
  localparam int ServeTicks = 2;
  localparam int ScrW = 800, ScrH = 600, Bsz = 8, PadH = 80, PadW = 10;
  localparam int P1X = 20, P2X = 770, Spd = 4, WinScore = 7;
  localparam int CX = 396, CY = 296;
  localparam int ModeServe = 0, ModePlay = 1, ModeOver = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        pause   = 1'b0;
  logic [10:0] p1_y    = '0;
  logic [10:0] p2_y    = '0;
  logic [10:0] ball_x, ball_y;
  logic [3:0]  score1, score2;
  logic        point_p1, point_p2, serving, game_over;

  int vectors     = 0;
  int miscompares = 0;

  int m_tcnt, m_scnt, m_mode, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pt1, m_pt2;

  ball_engine #(
    .TICK_DIV   (TickDiv),
    .SERVE_TICKS(ServeTicks)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .pause    (pause),
    .p1_y     (p1_y),
    .p2_y     (p2_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .score1   (score1),
    .score2   (score2),
    .point_p1 (point_p1),
    .point_p2 (point_p2),
    .serving  (serving),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_scnt = 0; m_mode = ModeServe;
    m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_pt1 = 0; m_pt2 = 0;
  endtask

  function automatic bit overlaps(input int by, input int py);
    return (by + Bsz > py) && (by < py + PadH);
  endfunction

  task automatic model_play_tick();
    int nx, ndx, ny, ndy, scorer;
    nx = m_x; ndx = m_dx; ny = m_y; ndy = m_dy; scorer = 0;
    if (m_dy == 1 && m_y + Spd >= ScrH - Bsz) begin ny = ScrH - Bsz; ndy = 0; end
    else if (m_dy == 0 && m_y <= Spd)         begin ny = 0;          ndy = 1; end
    else ny = (m_dy == 1) ? m_y + Spd : m_y - Spd;
    if (m_dx == 0) begin
      if (m_x >= P1X + PadW && m_x - Spd < P1X + PadW && overlaps(m_y, int'(p1_y))) begin
        nx = P1X + PadW; ndx = 1;
      end else if (m_x < Spd) scorer = 2;
      else nx = m_x - Spd;
    end else begin
      if (m_x + Bsz <= P2X && m_x + Bsz + Spd > P2X && overlaps(m_y, int'(p2_y))) begin
        nx = P2X - Bsz; ndx = 0;
      end else if (m_x + Bsz + Spd > ScrW) scorer = 1;
      else nx = m_x + Spd;
    end
    if (scorer != 0) begin
      m_x = CX; m_y = CY;
      if (scorer == 1) begin m_s1++; m_pt1 = 1; m_dx = 1; end
      else             begin m_s2++; m_pt2 = 1; m_dx = 0; end
      m_mode = (m_s1 == WinScore || m_s2 == WinScore) ? ModeOver : ModeServe;
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic model_step();
    bit eff;
    eff    = (m_tcnt == TickDiv - 1) && !pause;
    m_tcnt = (m_tcnt + 1) % TickDiv;
    m_pt1  = 0; m_pt2 = 0;
    case (m_mode)
      ModeServe: if (eff) begin
        m_scnt++;
        if (m_scnt == ServeTicks) begin m_scnt = 0; m_mode = ModePlay; end
      end
      ModePlay: if (eff) model_play_tick();
      default: if (start) begin m_s1 = 0; m_s2 = 0; m_scnt = 0; m_mode = ModeServe; end
    endcase
  endtask

  task automatic compare_all();
    check_val("ball_x",    int'(ball_x),    m_x);
    check_val("ball_y",    int'(ball_y),    m_y);
    check_val("score1",    int'(score1),    m_s1);
    check_val("score2",    int'(score2),    m_s2);
    check_val("point_p1",  int'(point_p1),  m_pt1);
    check_val("point_p2",  int'(point_p2),  m_pt2);
    check_val("serving",   int'(serving),   int'(m_mode == ModeServe));
    check_val("game_over", int'(game_over), int'(m_mode == ModeOver));
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // Paddle near the ball row; the offset straddles both overlap boundaries.
  function automatic logic [10:0] track(input int by);
    int py;
    py = by - ($urandom_range(0, 92) - 10);
    if (py < 0) py = 0;
    return 11'(py);
  endfunction

  task automatic drive_random(input bit p2_miss);
    if (p2_miss) begin
      p1_y  = 11'(m_y >= 70 ? m_y - 70 + $urandom_range(0, 70) : $urandom_range(0, m_y));
      p2_y  = (m_y >= 260) ? 11'd0 : 11'd500;
      pause = 1'b0;
      start = 1'b0;
    end else begin
      p1_y  = ($urandom_range(0, 99) < 85) ? track(m_y) : 11'($urandom_range(0, 520));
      p2_y  = ($urandom_range(0, 99) < 85) ? track(m_y) : 11'($urandom_range(0, 520));
      pause = ($urandom_range(0, 99) < 3);
      start = ($urandom_range(0, 99) < 2);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_x"},    int'(ball_x),    CX);
    check_val({pfx, "_y"},    int'(ball_y),    CY);
    check_val({pfx, "_s1"},   int'(score1),    0);
    check_val({pfx, "_s2"},   int'(score2),    0);
    check_val({pfx, "_pt1"},  int'(point_p1),  0);
    check_val({pfx, "_pt2"},  int'(point_p2),  0);
    check_val({pfx, "_srv"},  int'(serving),   1);
    check_val({pfx, "_over"}, int'(game_over), 0);
  endtask

  initial begin
    int budget, sx, sy;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Opening serve: two ticks of hold, then the first move lands at (400,300).
    p1_y = 11'd260;
    p2_y = 11'd260;
    for (int i = 0; i < 8; i++) step();
    check_val("serve_over", int'(serving), 0);
    for (int i = 0; i < 4; i++) step();
    check_val("first_x", int'(ball_x), 400);
    check_val("first_y", int'(ball_y), 300);

    for (int i = 0; i < 2000; i++) begin
      drive_random(1'b0);
      step();
    end

    // Pause mid-rally for 20 ticks.
    start = 1'b0;
    pause = 1'b0;
    if (m_mode == ModeOver) begin start = 1'b1; step(); start = 1'b0; end
    budget = 200;
    while (m_mode != ModePlay && budget > 0) begin
      p1_y = track(m_y); p2_y = track(m_y); step(); budget--;
    end
    check_val("reach_play", int'(serving == 1'b0 && game_over == 1'b0), 1);
    sx = m_x; sy = m_y;
    pause = 1'b1;
    for (int i = 0; i < 20 * TickDiv; i++) step();
    check_val("pause_x", int'(ball_x), sx);
    check_val("pause_y", int'(ball_y), sy);
    pause = 1'b0;

    // Fresh game where only player 1 can score.
    if (m_mode == ModeOver) begin start = 1'b1; step(); start = 1'b0; end
    budget = 30000;
    while (m_mode != ModeOver && budget > 0) begin
      drive_random(1'b1); step(); budget--;
    end
    check_val("go_flag",   int'(game_over), 1);
    check_val("go_score1", int'(score1),    WinScore);
    for (int i = 0; i < 10 * TickDiv; i++) begin
      drive_random(1'b1); step();
    end
    check_val("go_hold_x", int'(ball_x), CX);
    check_val("go_hold_y", int'(ball_y), CY);
    check_val("go_hold_s", int'(score1), WinScore);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart_s1",  int'(score1),  0);
    check_val("restart_srv", int'(serving), 1);

    for (int i = 0; i < 600; i++) begin
      drive_random(1'b0);
      step();
    end

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      drive_random(1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
